// File: rtl/aoc_pkg.sv
// Shared types and constants for the serial puzzle solver: UART FSM states,
// ASCII digit bounds and the active-low hex glyph table.
package aoc_pkg;

    localparam int unsigned DEF_CLKS_PER_BIT = 217;
    localparam int unsigned DEF_ANSWER_W     = 64;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Segment order {a,b,c,d,e,f,g}; 0 lights the segment.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/aoc_solver.sv
// Streaming solver: accumulates every terminated ASCII decimal integer into answer.
module aoc_solver #(
    parameter int unsigned ANSWER_W = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] answer_lo
);
    import aoc_pkg::*;

    logic [ANSWER_W-1:0] answer;
    logic [ANSWER_W-1:0] cur;
    logic                in_num;
    logic                is_digit;

    assign is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);

    // A number only counts once a non-digit byte terminates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            answer <= '0;
            cur    <= '0;
            in_num <= 1'b0;
        end else if (rx_valid) begin
            if (is_digit) begin
                cur    <= cur * ANSWER_W'(10) + ANSWER_W'(rx_byte - ASCII_0);
                in_num <= 1'b1;
            end else if (in_num) begin
                answer <= answer + cur;
                cur    <= '0;
                in_num <= 1'b0;
            end
        end
    end

    assign answer_lo = answer[7:0];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-FF synchroniser and mid-bit sampling.
// Optional RX_FRAME_CHECK_EN: drop frames with a low stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    import aoc_pkg::*;

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    uart_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_n;
    logic [7:0]       byte_n;
    logic             valid_n;
    logic             rx_meta, rx_sync;
`ifdef RX_FRAME_CHECK_EN
    logic             wait_high, wait_high_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
            wait_high <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            rx_byte  <= byte_n;
            rx_valid <= valid_n;
`ifdef RX_FRAME_CHECK_EN
            wait_high <= wait_high_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        byte_n  = rx_byte;
        valid_n = 1'b0;
`ifdef RX_FRAME_CHECK_EN
        wait_high_n = wait_high;
`endif
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
`ifdef RX_FRAME_CHECK_EN
                // After a framing error the line must return high before a new start bit.
                if (wait_high) begin
                    if (rx_sync) wait_high_n = 1'b0;
                end else if (!rx_sync) begin
                    state_n = START;
                end
`else
                if (!rx_sync) state_n = START;
`endif
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n  = '0;
                    byte_n = {rx_sync, rx_byte[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
`ifdef RX_FRAME_CHECK_EN
                    if (rx_sync) valid_n     = 1'b1;
                    else         wait_high_n = 1'b1;
`else
                    valid_n = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/aoc_serial_top.sv
// FPGA top: UART receiver feeding the solver, low answer byte shown on two 7-seg digits.
// Define RX_FRAME_CHECK_EN to drop frames whose stop bit is low.
module aoc_serial_top #(
    parameter int unsigned CLKS_PER_BIT = aoc_pkg::DEF_CLKS_PER_BIT,
    parameter int unsigned ANSWER_W     = aoc_pkg::DEF_ANSWER_W
) (
    input  logic CLK,
    input  logic SW1,
    input  logic RX,
    output logic S1_A, output logic S1_B, output logic S1_C, output logic S1_D,
    output logic S1_E, output logic S1_F, output logic S1_G,
    output logic S2_A, output logic S2_B, output logic S2_C, output logic S2_D,
    output logic S2_E, output logic S2_F, output logic S2_G
);
    import aoc_pkg::*;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] answer_lo;
    logic [6:0] seg1, seg2;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (CLK),
        .rst      (SW1),
        .rx       (RX),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte)
    );

    aoc_solver #(.ANSWER_W(ANSWER_W)) sol (
        .clk       (CLK),
        .rst       (SW1),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .answer_lo (answer_lo)
    );

    always_ff @(posedge CLK) begin
        if (SW1) begin
            seg1 <= seg7_glyph(4'h0);
            seg2 <= seg7_glyph(4'h0);
        end else begin
            seg1 <= seg7_glyph(answer_lo[7:4]);
            seg2 <= seg7_glyph(answer_lo[3:0]);
        end
    end

    assign {S1_A, S1_B, S1_C, S1_D, S1_E, S1_F, S1_G} = seg1;
    assign {S2_A, S2_B, S2_C, S2_D, S2_E, S2_F, S2_G} = seg2;

endmodule

// File: tb/tb_aoc_serial_top.sv
// Scoreboard bench for aoc_serial_top: serial stimulus, reference solver model, decoupled monitor.
module tb_aoc_serial_top;

    localparam int unsigned CPB    = 24;
    localparam int unsigned CLK_NS = 40;
    localparam int unsigned BIT_NS = CPB * CLK_NS;

    logic clk = 1'b0;
    logic sw1 = 1'b1;
    logic rx  = 1'b1;
    logic s1_a, s1_b, s1_c, s1_d, s1_e, s1_f, s1_g;
    logic s2_a, s2_b, s2_c, s2_d, s2_e, s2_f, s2_g;
    logic [6:0] seg1_v, seg2_v;

    assign seg1_v = {s1_a, s1_b, s1_c, s1_d, s1_e, s1_f, s1_g};
    assign seg2_v = {s2_a, s2_b, s2_c, s2_d, s2_e, s2_f, s2_g};

    aoc_serial_top #(.CLKS_PER_BIT(CPB), .ANSWER_W(64)) dut (
        .CLK(clk), .SW1(sw1), .RX(rx),
        .S1_A(s1_a), .S1_B(s1_b), .S1_C(s1_c), .S1_D(s1_d), .S1_E(s1_e), .S1_F(s1_f), .S1_G(s1_g),
        .S2_A(s2_a), .S2_B(s2_b), .S2_C(s2_c), .S2_D(s2_d), .S2_E(s2_e), .S2_F(s2_f), .S2_G(s2_g)
    );

    initial forever #(CLK_NS / 2) clk = ~clk;

    typedef struct {
        logic [7:0]      b;
        longint unsigned ans;
    } exp_t;

    exp_t            sb[$];
    longint unsigned m_cur, m_ans;
    bit              m_in;
    int              checks   = 0;
    int              failures = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Standard hex glyphs as lit-segment masks {a..g}; the pins are active-low.
    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] lit;
        case (n)
            4'h0: lit = 7'h7E; 4'h1: lit = 7'h30; 4'h2: lit = 7'h6D; 4'h3: lit = 7'h79;
            4'h4: lit = 7'h33; 4'h5: lit = 7'h5B; 4'h6: lit = 7'h5F; 4'h7: lit = 7'h70;
            4'h8: lit = 7'h7F; 4'h9: lit = 7'h7B; 4'hA: lit = 7'h77; 4'hB: lit = 7'h1F;
            4'hC: lit = 7'h4E; 4'hD: lit = 7'h3D; 4'hE: lit = 7'h4F; default: lit = 7'h47;
        endcase
        return ~lit;
    endfunction

    // Reference: digits extend the current number, any other byte closes it.
    function automatic void model_byte(input logic [7:0] b);
        exp_t e;
        if (b >= 8'h30 && b <= 8'h39) begin
            m_cur = m_cur * 64'd10 + 64'(b - 8'h30);
            m_in  = 1'b1;
        end else if (m_in) begin
            m_ans = m_ans + m_cur;
            m_cur = 0;
            m_in  = 1'b0;
        end
        e.b   = b;
        e.ans = m_ans;
        sb.push_back(e);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        if (bad_stop) begin
            rx = 1'b0;
            #(BIT_NS * 3 / 4);
            rx = 1'b1;
            #(BIT_NS * 5 / 4);
        end else begin
            rx = 1'b1;
            #(BIT_NS);
        end
    endtask

    task automatic send_char(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        sw1 = 1'b1;
        repeat (cycles) @(negedge clk);
        sw1 = 1'b0;
        m_cur = 0;
        m_ans = 0;
        m_in  = 1'b0;
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    // Monitor: every received byte is matched against the scoreboard, then answer and display.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (dut.u_rx.rx_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx_valid: got byte 0x%0h expected none", dut.u_rx.rx_byte);
                end else begin
                    e = sb.pop_front();
                    chk("rx_byte", 64'(dut.u_rx.rx_byte), 64'(e.b));
                    @(posedge clk); @(negedge clk);
                    chk("answer", dut.sol.answer, e.ans);
                    @(posedge clk); @(negedge clk);
                    chk("seg1", 64'(seg1_v), 64'(exp_seg(e.ans[7:4])));
                    chk("seg2", 64'(seg2_v), 64'(exp_seg(e.ans[3:0])));
                end
            end
        end
    end

    initial begin : stimulus
        int         r;
        logic [7:0] c;

        m_cur = 0; m_ans = 0; m_in = 1'b0;
        do_reset(2);
        chk("reset_answer", dut.sol.answer, 64'd0);
        chk("reset_seg1", 64'(seg1_v), 64'(7'b0000001));
        chk("reset_seg2", 64'(seg2_v), 64'(7'b0000001));

        send_str("12\n34\n");
        settle();
        chk("sum_12_34", dut.sol.answer, 64'd46);
        chk("sum_seg1_2", 64'(seg1_v), 64'(7'b0010010));
        chk("sum_seg2_E", 64'(seg2_v), 64'(7'b0110000));

        do_reset(2);
        send_str("7 8");
        settle();
        chk("trailing_not_added", dut.sol.answer, 64'd7);
        send_str("\n");
        settle();
        chk("trailing_flushed", dut.sol.answer, 64'd15);

        // Short low pulses on an idle line must not start a frame.
        #(7);
        rx = 1'b0; #(20); rx = 1'b1;
        #(BIT_NS);
        rx = 1'b0; #(CLK_NS * 4); rx = 1'b1;
        #(BIT_NS * 12);
        chk("glitch_ignored", dut.sol.answer, 64'd15);

        // Reset in the middle of a '9' frame, then a clean "5\n".
        rx = 1'b0; #(BIT_NS);
        rx = 1'b1; #(BIT_NS);
        rx = 1'b0; #(BIT_NS);
        rx = 1'b0; #(BIT_NS / 2);
        @(negedge clk);
        sw1 = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        sw1 = 1'b0;
        m_cur = 0; m_ans = 0; m_in = 1'b0;
        #(BIT_NS * 12);
        send_str("5\n");
        settle();
        chk("reset_mid_byte", dut.sol.answer, 64'd5);

        // Randomised stream with occasional very long numbers to force wrap-around.
        do_reset(2);
        for (int n = 0; n < 140; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 9)       c = 8'h30 + 8'($urandom_range(0, 9));
            else if (r < 12) c = 8'h0A;
            else if (r < 14) c = 8'h20;
            else if (r < 16) c = 8'h2D;
            else if (r < 19) c = 8'($urandom_range(0, 255));
            else begin
                for (int k = 0; k < 22; k++) send_char(8'h30 + 8'($urandom_range(0, 9)));
                c = 8'h2C;
            end
            send_char(c);
            if ($urandom_range(0, 3) == 0) #($urandom_range(1, 60) * 10);
        end
        send_char(8'h0A);
        settle();
        chk("random_final", dut.sol.answer, m_ans);

        // A '3' frame with a low stop bit.
        do_reset(2);
`ifdef RX_FRAME_CHECK_EN
        send_byte(8'h33, 1'b1);
`else
        model_byte(8'h33);
        send_byte(8'h33, 1'b1);
`endif
        send_char(8'h0A);
        settle();
`ifdef RX_FRAME_CHECK_EN
        chk("bad_stop_dropped", dut.sol.answer, 64'd0);
`else
        chk("bad_stop_accepted", dut.sol.answer, 64'd3);
`endif

        #(BIT_NS * 4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
